// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect player.
// State encoding, sound_id codes, counter widths and default timing.
package sfx_pkg;

    localparam int DUR_W  = 24;
    localparam int HALF_W = 20;

    localparam int DEF_HALF_A = 56818;
    localparam int DEF_HALF_B = 28409;
    localparam int DEF_DUR    = 5000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TONE_A = 2'd1,
        ST_TONE_B = 2'd2
    } state_e;

    localparam logic [1:0] SID_IDLE = 2'd0;
    localparam logic [1:0] SID_A    = 2'd1;
    localparam logic [1:0] SID_B    = 2'd2;

endpackage

// File: rtl/tone_gen.sv
// Half-period counter plus toggle flop producing a square wave.
// wave_nxt_o is the value the toggle flop takes on the next edge.
module tone_gen
    import sfx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              restart_i,
    input  logic              enable_i,
    input  logic [HALF_W-1:0] half_i,
    output logic              wave_nxt_o
);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              wave_q, wave_d;

    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (restart_i) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (enable_i) begin
            if (cnt_q == half_i - 1'b1) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave_nxt_o = wave_d;

endmodule

// File: rtl/sfx_player.sv
// Two-tone sound-effect player: edge-triggered A/B tones with a
// one-deep pending A queued behind B, square-wave speaker drive.
module sfx_player
    import sfx_pkg::*;
#(
    parameter int HALF_A = DEF_HALF_A,
    parameter int HALF_B = DEF_HALF_B,
    parameter int DUR    = DEF_DUR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig_a,
    input  logic       trig_b,
    input  logic       mute,
    output logic       spkr,
    output logic       busy,
    output logic [1:0] sound_id
);

    if (HALF_A < 1 || HALF_A > (1 << HALF_W) - 1 ||
        HALF_B < 1 || HALF_B > (1 << HALF_W) - 1 ||
        DUR < 1 || DUR > (1 << DUR_W) - 1) begin : g_param_chk
        $error("sfx_player: HALF_A/HALF_B/DUR out of counter range");
    end

    localparam logic [DUR_W-1:0]  DUR_LAST = DUR_W'(DUR - 1);
    localparam logic [HALF_W-1:0] HA       = HALF_W'(HALF_A);
    localparam logic [HALF_W-1:0] HB       = HALF_W'(HALF_B);

    state_e           state_q, state_d;
    logic             pend_q, pend_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             prev_a_q, prev_b_q;
    logic             spkr_q, spkr_d;
    logic             edge_a, edge_b, last, start, wave_nxt;

    assign edge_a = trig_a & ~prev_a_q;
    assign edge_b = trig_b & ~prev_b_q;
    assign last   = (dur_q == DUR_LAST);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (edge_b) begin
                    state_d = ST_TONE_B;
                    start   = 1'b1;
                    pend_d  = edge_a;
                end else if (edge_a) begin
                    state_d = ST_TONE_A;
                    start   = 1'b1;
                end
            end
            ST_TONE_A: begin
                if (edge_b) begin
                    state_d = ST_TONE_B;
                    start   = 1'b1;
                    pend_d  = edge_a;
                end else if (edge_a) begin
                    start = 1'b1;
                end else if (last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TONE_B: begin
                if (edge_a) pend_d = 1'b1;
                if (edge_b) begin
                    start = 1'b1;
                end else if (last) begin
                    // Queued A plays straight after B without an idle gap
                    if (pend_q || edge_a) begin
                        state_d = ST_TONE_A;
                        start   = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dur_d = dur_q + 1'b1;
        if (start || state_d == ST_IDLE) dur_d = '0;
    end

    tone_gen u_tone (
        .clk       (clk),
        .reset     (reset),
        .restart_i (start || state_d == ST_IDLE),
        .enable_i  (1'b1),
        .half_i    ((state_d == ST_TONE_B) ? HB : HA),
        .wave_nxt_o(wave_nxt)
    );

    assign spkr_d = (state_d != ST_IDLE) && !mute && wave_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            dur_q    <= '0;
            prev_a_q <= 1'b1;
            prev_b_q <= 1'b1;
            spkr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            dur_q    <= dur_d;
            prev_a_q <= trig_a;
            prev_b_q <= trig_b;
            spkr_q   <= spkr_d;
        end
    end

    always_comb begin
        sound_id = SID_IDLE;
        unique case (state_q)
            ST_TONE_A: sound_id = SID_A;
            ST_TONE_B: sound_id = SID_B;
            default:   sound_id = SID_IDLE;
        endcase
    end

    assign spkr = spkr_q;
    assign busy = (state_q != ST_IDLE);

endmodule
